// File: rtl/pll_rst_sequencer_if.sv
// Signal bundle between the PLL reset sequencer (slave) and the PLL/SoC side (master).
interface pll_rst_sequencer_if #(
    parameter int N_CH = 3
);
    logic            pll_lock;
    logic            sw_reinit;
    logic            pll_reset;
    logic [N_CH-1:0] rst_out;
    logic            ready;
    logic            lock_lost;
    logic [7:0]      retry_cnt;

    modport master (
        output pll_lock, sw_reinit,
        input  pll_reset, rst_out, ready, lock_lost, retry_cnt
    );

    modport slave (
        input  pll_lock, sw_reinit,
        output pll_reset, rst_out, ready, lock_lost, retry_cnt
    );
endinterface

// File: rtl/pll_rst_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for a stable synchronised lock with timeout/retry,
// then releases N_CH reset domains in ascending order and tears them all down on lock loss.
module pll_rst_sequencer #(
    parameter int N_CH         = 3,
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 27000,
    parameter int STABLE_CYC   = 270,
    parameter int STEP_CYC     = 64
) (
    input  logic               clkin,
    input  logic               reset,
    pll_rst_sequencer_if.slave bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_P = max2(max2(PLL_RST_CYC, LOCK_TIMEOUT), max2(STABLE_CYC, STEP_CYC));
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYC - 1);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAITLK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_lock_meta;
    logic            r_lock_s;
    logic            r_pll_reset;
    logic [N_CH-1:0] r_rst_out;
    logic            r_ready;
    logic            r_lock_lost;
    logic [7:0]      r_retry_cnt;
    logic [N_CH-1:0] w_rst_shift;

    // Releasing the lowest still-asserted bit is a left shift with zero fill.
    assign w_rst_shift = r_rst_out << 1;

    // pll_lock is asynchronous to clkin: two-flop synchroniser before any decision uses it.
    always_ff @(posedge clkin or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, giving a true 2-stage pipe.
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= bus.pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state     <= S_PLLRST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_retry_cnt <= '0;
        end else if (bus.sw_reinit) begin
            // Software restart outranks a simultaneous lock loss, so lock_lost is cleared, not set.
            r_state     <= S_PLLRST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            case (r_state)
                S_PLLRST: begin
                    if (r_cnt == PLL_RST_LAST) begin
                        r_state     <= S_WAITLK;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAITLK: begin
                    if (r_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state     <= S_PLLRST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        if (r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        r_state <= S_WAITLK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_rst_out <= w_rst_shift;
                        r_state   <= (w_rst_shift == '0) ? S_RUN : S_RELEASE;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!r_lock_s) begin
                        r_state     <= S_PLLRST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        r_rst_out   <= '1;
                    end else if (r_cnt == STEP_LAST) begin
                        r_rst_out <= w_rst_shift;
                        r_cnt     <= '0;
                        if (w_rst_shift == '0) r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        r_state     <= S_PLLRST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        r_rst_out   <= '1;
                        r_ready     <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_PLLRST;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_rst_out   <= '1;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_reset = r_pll_reset;
    assign bus.rst_out   = r_rst_out;
    assign bus.ready     = r_ready;
    assign bus.lock_lost = r_lock_lost;
    assign bus.retry_cnt = r_retry_cnt;
endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Bench for pll_rst_sequencer: hand-derived vector table, directed corner sequences and a
// randomised run against a phase/elapsed-time reference model.
module tb_pll_rst_sequencer;
    localparam int N_CH         = 3;
    localparam int PLL_RST_CYC  = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int STABLE_CYC   = 8;
    localparam int STEP_CYC     = 3;

    logic clkin = 1'b0;
    logic reset = 1'b1;

    pll_rst_sequencer_if #(.N_CH(N_CH)) bus ();

    pll_rst_sequencer #(
        .N_CH        (N_CH),
        .PLL_RST_CYC (PLL_RST_CYC),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYC  (STABLE_CYC),
        .STEP_CYC    (STEP_CYC)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clkin = ~clkin;

    int    n_cmp = 0;
    int    n_bad = 0;
    string tag   = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h, expected %0h (t=%0t)", tag, name, act, exp, $time);
        end
    endtask

    // Reference model: a coarse phase (0 pll reset, 1 wait lock, 2 stable, 3 release+run)
    // plus elapsed cycles in that phase; released domains are derived arithmetically.
    int   m_phase, m_t, m_retry;
    logic m_lost, m_s1, m_s2;

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_retry = 0; m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_step(input logic lk, input logic sw);
        logic ls;
        ls = m_s2; m_s2 = m_s1; m_s1 = lk;
        if (sw) begin
            m_phase = 0; m_t = 0; m_retry = 0; m_lost = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_t++;
                    if (m_t == PLL_RST_CYC) begin m_phase = 1; m_t = 0; end
                end
                1: if (ls) begin
                    m_phase = 2; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == LOCK_TIMEOUT) begin
                        m_phase = 0; m_t = 0;
                        if (m_retry < 255) m_retry++;
                    end
                end
                2: if (!ls) begin
                    m_phase = 1; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == STABLE_CYC) begin m_phase = 3; m_t = 0; end
                end
                default: if (!ls) begin
                    if (m_t >= (N_CH - 1) * STEP_CYC) m_lost = 1'b1;
                    m_phase = 0; m_t = 0;
                end else begin
                    m_t++;
                end
            endcase
        end
    endtask

    function automatic logic [N_CH-1:0] model_rst();
        logic [N_CH-1:0] m;
        int r;
        m = '1;
        if (m_phase == 3) begin
            r = 1 + m_t / STEP_CYC;
            if (r > N_CH) r = N_CH;
            m = m << r;
        end
        return m;
    endfunction

    task automatic compare_model();
        check("m_pll_reset", bus.pll_reset, m_phase == 0);
        check("m_rst_out", bus.rst_out, model_rst());
        check("m_ready", bus.ready, (m_phase == 3) && (m_t >= (N_CH - 1) * STEP_CYC + 1));
        check("m_lock_lost", bus.lock_lost, m_lost);
        check("m_retry_cnt", bus.retry_cnt, m_retry);
    endtask

    task automatic tick();
        @(posedge clkin);
        model_step(bus.pll_lock, bus.sw_reinit);
        #1;
        compare_model();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_pll_reset"}, bus.pll_reset, 1);
        check({name, "_rst_out"}, bus.rst_out, 3'b111);
        check({name, "_ready"}, bus.ready, 0);
        check({name, "_lock_lost"}, bus.lock_lost, 0);
        check({name, "_retry_cnt"}, bus.retry_cnt, 0);
    endtask

    task automatic do_reset();
        bus.pll_lock  = 1'b0;
        bus.sw_reinit = 1'b0;
        @(negedge clkin);
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_values("rst");
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < budget) begin tick(); k++; end
        check(name, bus.ready, 1);
    endtask

    typedef struct {
        logic            lock;
        logic            sw;
        logic            exp_pll_reset;
        logic [N_CH-1:0] exp_rst;
        logic            exp_ready;
    } vec_t;

    vec_t vecs[24];

    initial begin
        // Edge e = i+1 after reset release; lock seen from edge 6 onward.
        for (int i = 0; i < 24; i++) begin
            int e;
            e = i + 1;
            vecs[i].lock          = (e >= 6);
            vecs[i].sw            = 1'b0;
            vecs[i].exp_pll_reset = (e <= 3);
            vecs[i].exp_rst       = (e < 16) ? 3'b111 : (e < 19) ? 3'b110 : (e < 22) ? 3'b100 : 3'b000;
            vecs[i].exp_ready     = (e >= 23);
        end

        bus.pll_lock  = 1'b0;
        bus.sw_reinit = 1'b0;

        tag = "t1_table";
        do_reset();
        for (int i = 0; i < 24; i++) begin
            bus.pll_lock  = vecs[i].lock;
            bus.sw_reinit = vecs[i].sw;
            tick();
            check($sformatf("v%0d_pll_reset", i), bus.pll_reset, vecs[i].exp_pll_reset);
            check($sformatf("v%0d_rst_out", i), bus.rst_out, vecs[i].exp_rst);
            check($sformatf("v%0d_ready", i), bus.ready, vecs[i].exp_ready);
        end

        tag = "t2_retry";
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            tick();
            if (e % 24 == 0) begin
                check("retry_step", bus.retry_cnt, e / 24);
                check("repulse_hi", bus.pll_reset, 1);
            end
            if (e % 24 == 4) check("repulse_lo", bus.pll_reset, 0);
        end
        for (int e = 0; e < 6200; e++) tick();
        check("retry_sat", bus.retry_cnt, 255);
        for (int e = 0; e < 48; e++) tick();
        check("retry_hold", bus.retry_cnt, 255);

        tag = "t3_glitch";
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            bus.pll_lock = (e >= 6 && e != 13);
            tick();
            if (e >= 16 && e <= 23) check("no_early_release", bus.rst_out, 3'b111);
        end
        check("release_after_restable", bus.rst_out, 3'b110);

        tag = "t4_lockloss";
        do_reset();
        bus.pll_lock = 1'b1;
        wait_ready("reach_run", 60);
        bus.pll_lock = 1'b0;
        tick();
        tick();
        check("sync_delay_rst", bus.rst_out, 3'b000);
        check("sync_delay_ready", bus.ready, 1);
        tick();
        check("loss_rst", bus.rst_out, 3'b111);
        check("loss_ready", bus.ready, 0);
        check("loss_sticky", bus.lock_lost, 1);
        check("loss_pll_reset", bus.pll_reset, 1);
        bus.pll_lock = 1'b1;
        wait_ready("recover", 100);
        check("still_sticky", bus.lock_lost, 1);

        tag = "t5_reinit";
        bus.pll_lock = 1'b0;
        for (int e = 0; e < 30; e++) tick();
        check("pre_retry", bus.retry_cnt, 1);
        bus.pll_lock = 1'b1;
        begin
            int k;
            k = 0;
            while (bus.rst_out !== 3'b100 && k < 60) begin tick(); k++; end
            check("reach_100", bus.rst_out, 3'b100);
        end
        bus.sw_reinit = 1'b1;
        tick();
        bus.sw_reinit = 1'b0;
        check("sw_rst", bus.rst_out, 3'b111);
        check("sw_pll_reset", bus.pll_reset, 1);
        check("sw_lost", bus.lock_lost, 0);
        check("sw_retry", bus.retry_cnt, 0);
        wait_ready("sw_recover", 60);
        bus.pll_lock = 1'b0;
        tick();
        tick();
        bus.sw_reinit = 1'b1;
        tick();
        bus.sw_reinit = 1'b0;
        check("sw_wins_lost", bus.lock_lost, 0);
        check("sw_wins_rst", bus.rst_out, 3'b111);

        tag = "t6_async";
        bus.pll_lock = 1'b1;
        wait_ready("pre_async", 80);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clkin);
        reset = 1'b0;

        tag = "rand";
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) bus.pll_lock = ~bus.pll_lock;
            bus.sw_reinit = ($urandom_range(0, 299) == 0);
            tick();
        end
        bus.sw_reinit = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
